// File: rtl/store_scoreboard_pkg.sv
// Shared types and constants for the store scoreboard.
// Error capture record and FSM state encoding live here.
package sb_pkg;

   typedef enum logic [1:0] {
      SB_IDLE,
      SB_RUN,
      SB_PASS,
      SB_FAIL
   } sb_state_t;

   localparam int SB_W = 32;

   localparam logic [15:0] MISMATCH_MAX = 16'hFFFF;

   typedef struct packed {
      logic [31:0]     pc;
      logic [SB_W-1:0] addr;
      logic [SB_W-1:0] data;
   } sb_err_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == MISMATCH_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/store_scoreboard_if.sv
// Data-memory write bus as seen between the core and the scoreboard.
// The core side drives it, the scoreboard only observes.
interface store_scoreboard_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              memwrite;
   logic [ADDR_W-1:0] dataadr;
   logic [DATA_W-1:0] writedata;
   logic [31:0]       pc;

   modport master (
      output memwrite,
      output dataadr,
      output writedata,
      output pc
   );

   modport slave (
      input memwrite,
      input dataadr,
      input writedata,
      input pc
   );

endinterface

// File: rtl/store_scoreboard_match_unit.sv
// Comparator array over the expected-store table with a
// lowest-index-wins priority encoder.
module sb_match_unit #(
   parameter int DEPTH = 8,
   parameter int KEY_W = 64,
   parameter int IDX_W = 3
) (
   input  logic [KEY_W-1:0]            i_key,
   input  logic [DEPTH-1:0][KEY_W-1:0] i_tab,
   input  logic [DEPTH-1:0]            i_mask,
   output logic                        o_hit,
   output logic [IDX_W-1:0]            o_hit_idx
);

   logic [DEPTH-1:0] w_eq;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_cmp
         assign w_eq[g] = i_mask[g] && (i_tab[g] == i_key);
      end
   endgenerate

   // Scan downwards so the lowest matching index is the one kept.
   always_comb begin
      o_hit     = 1'b0;
      o_hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_eq[i]) begin
            o_hit     = 1'b1;
            o_hit_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/store_scoreboard.sv
// Store scoreboard: checks core data-memory writes against a table of
// expected stores and reports pass, fail or timeout with first-error capture.
module store_scoreboard
   import sb_pkg::*;
#(
   parameter int  DEPTH       = 8,
   parameter int  ADDR_W      = 32,
   parameter int  DATA_W      = 32,
   parameter int  TIMEOUT     = 1024,
   parameter int  ORDERED     = 1,
   parameter int  STOP_ON_ERR = 1,
   localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_exp_we,
   input  logic [IDX_W-1:0]  i_exp_idx,
   input  logic [ADDR_W-1:0] i_exp_addr,
   input  logic [DATA_W-1:0] i_exp_data,
   input  logic [CNT_W-1:0]  i_num_exp,
   input  logic              i_start,
   store_scoreboard_if.slave bus,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_fail,
   output logic              o_timed_out,
   output logic [CNT_W-1:0]  o_match_cnt,
   output logic [15:0]       o_mismatch_cnt,
   output logic [31:0]       o_cycle_cnt,
   output logic [31:0]       o_err_pc,
   output logic [ADDR_W-1:0] o_err_addr,
   output logic [DATA_W-1:0] o_err_data
);

   localparam int KEY_W = ADDR_W + DATA_W;

   sb_state_t                   r_state;
   sb_state_t                   w_nxt;
   logic [DEPTH-1:0][KEY_W-1:0] r_tab;
   logic [DEPTH-1:0]            r_matched;
   logic [CNT_W-1:0]            r_num;
   logic [CNT_W-1:0]            r_match_cnt;
   logic [15:0]                 r_mis;
   logic [31:0]                 r_cycle;
   sb_err_t                     r_err;
   logic                        r_timed_out;

   logic [DEPTH-1:0] w_range;
   logic [DEPTH-1:0] w_ord_mask;
   logic [DEPTH-1:0] w_mask;
   logic             w_hit;
   logic [IDX_W-1:0] w_hit_idx;
   logic             w_store;
   logic             w_match;
   logic             w_miss;
   logic             w_final;
   logic             w_tmo;
   logic             w_bad_num;
   logic             w_start;
   logic             w_set_to;

   // Table has no reset so a program survives a scoreboard reset.
   always_ff @(posedge clk) begin
      if (i_exp_we && r_state == SB_IDLE) begin
         r_tab[i_exp_idx] <= {i_exp_addr, i_exp_data};
      end
   end

   always_comb begin
      w_range    = '0;
      w_ord_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_range[i]    = CNT_W'(i) < r_num;
         w_ord_mask[i] = CNT_W'(i) == r_match_cnt;
      end
   end

   assign w_mask = (ORDERED != 0) ? w_ord_mask : (w_range & ~r_matched);

   sb_match_unit #(
      .DEPTH (DEPTH),
      .KEY_W (KEY_W),
      .IDX_W (IDX_W)
   ) u_match (
      .i_key     ({bus.dataadr, bus.writedata}),
      .i_tab     (r_tab),
      .i_mask    (w_mask),
      .o_hit     (w_hit),
      .o_hit_idx (w_hit_idx)
   );

   assign w_store   = (r_state == SB_RUN) && bus.memwrite;
   assign w_match   = w_store && w_hit;
   assign w_miss    = w_store && !w_hit;
   assign w_final   = w_match && ((r_match_cnt + CNT_W'(1)) == r_num);
   assign w_tmo     = (TIMEOUT != 0) && (r_cycle == 32'(TIMEOUT - 1));
   assign w_bad_num = (i_num_exp == '0) || (i_num_exp > CNT_W'(DEPTH));
   assign w_start   = i_start && (r_state != SB_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SB_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // A final match beats the timeout; a mismatch on that cycle is not a timeout.
   always_comb begin
      w_nxt    = r_state;
      w_set_to = 1'b0;
      unique case (r_state)
         SB_RUN: begin
            if (w_final) begin
               w_nxt = SB_PASS;
            end else if (w_miss && (STOP_ON_ERR != 0 || w_tmo)) begin
               w_nxt = SB_FAIL;
            end else if (w_tmo) begin
               w_nxt    = SB_FAIL;
               w_set_to = 1'b1;
            end
         end
         default: begin
            if (i_start) begin
               w_nxt = w_bad_num ? SB_FAIL : SB_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_num       <= '0;
         r_match_cnt <= '0;
         r_matched   <= '0;
         r_mis       <= '0;
         r_cycle     <= '0;
         r_err       <= '0;
         r_timed_out <= 1'b0;
      end else if (w_start) begin
         r_num       <= i_num_exp;
         r_match_cnt <= '0;
         r_matched   <= '0;
         r_mis       <= '0;
         r_cycle     <= '0;
         r_err       <= '0;
         r_timed_out <= 1'b0;
      end else if (r_state == SB_RUN) begin
         r_timed_out <= w_set_to;
         if (w_nxt == SB_RUN) begin
            r_cycle <= r_cycle + 32'd1;
         end
         if (w_match) begin
            r_matched[w_hit_idx] <= 1'b1;
            r_match_cnt          <= r_match_cnt + CNT_W'(1);
         end
         if (w_miss) begin
            r_mis <= sat_inc(r_mis);
            if (r_mis == '0) begin
               r_err <= '{
                  pc:   bus.pc,
                  addr: SB_W'(bus.dataadr),
                  data: SB_W'(bus.writedata)
               };
            end
         end
      end
   end

   assign o_busy         = (r_state == SB_RUN);
   assign o_pass         = (r_state == SB_PASS);
   assign o_fail         = (r_state == SB_FAIL);
   assign o_done         = o_pass || o_fail;
   assign o_timed_out    = r_timed_out;
   assign o_match_cnt    = r_match_cnt;
   assign o_mismatch_cnt = r_mis;
   assign o_cycle_cnt    = r_cycle;
   assign o_err_pc       = r_err.pc;
   assign o_err_addr     = ADDR_W'(r_err.addr);
   assign o_err_data     = DATA_W'(r_err.data);

endmodule

// File: tb/tb_store_scoreboard.sv
// Bench for store_scoreboard: four parameter variants share one stimulus
// stream; each scenario checks the variant it targets.
module tb_store_scoreboard;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        exp_we = 1'b0;
   logic [2:0]  exp_idx = '0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_data = '0;
   logic [3:0]  num_exp = '0;
   logic        start = 1'b0;

   always #5 clk = ~clk;

   store_scoreboard_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   wire        w_busy [4];
   wire        w_done [4];
   wire        w_pass [4];
   wire        w_fail [4];
   wire        w_to   [4];
   wire [3:0]  w_mc   [4];
   wire [15:0] w_mis  [4];
   wire [31:0] w_cyc  [4];
   wire [31:0] w_epc  [4];
   wire [31:0] w_eadr [4];
   wire [31:0] w_edat [4];

   // 0: ordered, continue on error; 1: any order; 2: stop on error;
   // 3: stop on error with a 20-cycle timeout.
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_dut
         store_scoreboard #(
            .DEPTH       (8),
            .ADDR_W      (32),
            .DATA_W      (32),
            .TIMEOUT     ((g == 3) ? 20 : 1024),
            .ORDERED     ((g == 1) ? 0 : 1),
            .STOP_ON_ERR ((g >= 2) ? 1 : 0)
         ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .i_exp_we       (exp_we),
            .i_exp_idx      (exp_idx),
            .i_exp_addr     (exp_addr),
            .i_exp_data     (exp_data),
            .i_num_exp      (num_exp),
            .i_start        (start),
            .bus            (bus),
            .o_busy         (w_busy[g]),
            .o_done         (w_done[g]),
            .o_pass         (w_pass[g]),
            .o_fail         (w_fail[g]),
            .o_timed_out    (w_to[g]),
            .o_match_cnt    (w_mc[g]),
            .o_mismatch_cnt (w_mis[g]),
            .o_cycle_cnt    (w_cyc[g]),
            .o_err_pc       (w_epc[g]),
            .o_err_addr     (w_eadr[g]),
            .o_err_data     (w_edat[g])
         );
      end
   endgenerate

   typedef struct {
      int pass; int fail; int to; int mc;
      int mis;  int ea;   int ed; int epc;
   } exp_t;

   typedef struct {
      int          inst;
      int          num;
      int          ntab;
      int          nst;
      logic [63:0] tab [4];
      logic [63:0] st  [4];
      int          pc  [4];
      exp_t        ex;
   } vec_t;

   localparam int NV = 10;
   vec_t vt [NV];
   exp_t q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [63:0] E(input int a, input int d);
      return {32'(a), 32'(d)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      exp_we       = 1'b0;
      start        = 1'b0;
      bus.memwrite = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic load(input int idx, input logic [63:0] e);
      exp_we               = 1'b1;
      exp_idx              = 3'(idx);
      {exp_addr, exp_data} = e;
      tick();
      exp_we = 1'b0;
   endtask

   task automatic go(input int n);
      num_exp = 4'(n);
      start   = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [63:0] e, input int p);
      bus.memwrite                  = 1'b1;
      {bus.dataadr, bus.writedata} = e;
      bus.pc                        = 32'(p);
      tick();
      bus.memwrite = 1'b0;
   endtask

   task automatic wait_done(input int k, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 64 && !ok; c++) begin
         @(negedge clk);
         ok = w_done[k];
      end
   endtask

   task automatic chk_zero(input int k, input string tag);
      chk({tag, ".flags"},
          32'({w_busy[k], w_done[k], w_pass[k], w_fail[k], w_to[k]}), 0);
      chk({tag, ".match"}, 32'(w_mc[k]), 0);
      chk({tag, ".mis"}, 32'(w_mis[k]), 0);
      chk({tag, ".cyc"}, w_cyc[k], 0);
      chk({tag, ".err"}, w_epc[k] | w_eadr[k] | w_edat[k], 0);
   endtask

   task automatic cmp_res(input int k, input exp_t ex, input string tag);
      chk({tag, ".pass"}, 32'(w_pass[k]), ex.pass);
      chk({tag, ".fail"}, 32'(w_fail[k]), ex.fail);
      chk({tag, ".to"}, 32'(w_to[k]), ex.to);
      chk({tag, ".match"}, 32'(w_mc[k]), ex.mc);
      chk({tag, ".mis"}, 32'(w_mis[k]), ex.mis);
      chk({tag, ".eaddr"}, w_eadr[k], ex.ea);
      chk({tag, ".edata"}, w_edat[k], ex.ed);
      chk({tag, ".epc"}, w_epc[k], ex.epc);
   endtask

   task automatic setv(input int i, input int inst, input int num,
                       input int ntab, input int nst, input exp_t ex);
      vt[i].inst = inst;
      vt[i].num  = num;
      vt[i].ntab = ntab;
      vt[i].nst  = nst;
      vt[i].ex   = ex;
      for (int j = 0; j < 4; j++) begin
         vt[i].tab[j] = '0;
         vt[i].st[j]  = '0;
         vt[i].pc[j]  = 0;
      end
   endtask

   task automatic tab3(input int i);
      vt[i].tab[0] = E(0, 1);
      vt[i].tab[1] = E(4, 2);
      vt[i].tab[2] = E(8, 3);
   endtask

   task automatic st(input int i, input int s, input logic [63:0] e,
                     input int p);
      vt[i].st[s] = e;
      vt[i].pc[s] = p;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1);
   end

   initial begin
      bit   ok;
      exp_t ex;
      bus.memwrite  = 1'b0;
      bus.dataadr   = '0;
      bus.writedata = '0;
      bus.pc        = '0;

      setv(0, 0, 1, 1, 2, '{1, 0, 0, 1, 1, 80, 7, 'h10});
      vt[0].tab[0] = E(116, 6);
      st(0, 0, E(80, 7), 'h10);
      st(0, 1, E(116, 6), 'h14);
      setv(1, 0, 3, 3, 3, '{1, 0, 0, 3, 0, 0, 0, 0});
      tab3(1);
      st(1, 0, E(0, 1), 'h20);
      st(1, 1, E(4, 2), 'h24);
      st(1, 2, E(8, 3), 'h28);
      setv(2, 1, 3, 3, 3, '{1, 0, 0, 3, 0, 0, 0, 0});
      tab3(2);
      st(2, 0, E(8, 3), 0);
      st(2, 1, E(0, 1), 0);
      st(2, 2, E(4, 2), 0);
      setv(3, 1, 3, 3, 4, '{1, 0, 0, 3, 1, 0, 1, 'h34});
      tab3(3);
      st(3, 0, E(0, 1), 'h30);
      st(3, 1, E(0, 1), 'h34);
      st(3, 2, E(8, 3), 'h38);
      st(3, 3, E(4, 2), 'h3c);
      setv(4, 2, 1, 1, 1, '{0, 1, 0, 0, 1, 116, 5, 'h40});
      vt[4].tab[0] = E(116, 6);
      st(4, 0, E(116, 5), 'h40);
      setv(5, 0, 3, 3, 4, '{1, 0, 0, 3, 1, 4, 2, 'h50});
      tab3(5);
      st(5, 0, E(4, 2), 'h50);
      st(5, 1, E(0, 1), 'h54);
      st(5, 2, E(4, 2), 'h58);
      st(5, 3, E(8, 3), 'h5c);
      setv(6, 0, 0, 0, 0, '{0, 1, 0, 0, 0, 0, 0, 0});
      setv(7, 0, 9, 0, 0, '{0, 1, 0, 0, 0, 0, 0, 0});
      setv(8, 1, 2, 2, 2, '{1, 0, 0, 2, 0, 0, 0, 0});
      vt[8].tab[0] = E(0, 1);
      vt[8].tab[1] = E(0, 1);
      st(8, 0, E(0, 1), 0);
      st(8, 1, E(0, 1), 0);
      setv(9, 1, 2, 3, 3, '{1, 0, 0, 2, 1, 8, 3, 'h60});
      tab3(9);
      st(9, 0, E(8, 3), 'h60);
      st(9, 1, E(4, 2), 'h64);
      st(9, 2, E(0, 1), 'h68);

      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) chk_zero(k, $sformatf("rst%0d", k));

      for (int i = 0; i < NV; i++) begin
         do_reset();
         for (int t = 0; t < vt[i].ntab; t++) load(t, vt[i].tab[t]);
         go(vt[i].num);
         for (int s = 0; s < vt[i].nst; s++) store(vt[i].st[s], vt[i].pc[s]);
         q.push_back(vt[i].ex);
         wait_done(vt[i].inst, ok);
         ex = q.pop_front();
         if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d.done: got 0 want 1", i);
         end else begin
            cmp_res(vt[i].inst, ex, $sformatf("v%0d", i));
         end
      end

      // Timeout with no stores: fails after the twentieth RUN cycle.
      do_reset();
      load(0, E(116, 6));
      go(1);
      repeat (19) tick();
      chk("tmo.busy", 32'(w_busy[3]), 1);
      chk("tmo.cyc_pre", w_cyc[3], 19);
      wait_done(3, ok);
      chk("tmo.done", 32'(ok), 1);
      chk("tmo.fail", 32'(w_fail[3]), 1);
      chk("tmo.to", 32'(w_to[3]), 1);
      chk("tmo.cyc", w_cyc[3], 19);

      // Final match on the timeout cycle wins; table survived the reset.
      do_reset();
      go(1);
      repeat (19) tick();
      store(E(116, 6), 0);
      @(negedge clk);
      chk("tmo_hit.pass", 32'(w_pass[3]), 1);
      chk("tmo_hit.to", 32'(w_to[3]), 0);
      chk("tmo_hit.cyc", w_cyc[3], 19);

      // Reset mid-RUN, restart without reload, drop a table write in RUN.
      do_reset();
      load(0, E(0, 1));
      load(1, E(4, 2));
      load(2, E(8, 3));
      go(3);
      store(E(0, 1), 0);
      tick();
      chk("mid.busy", 32'(w_busy[0]), 1);
      chk("mid.match", 32'(w_mc[0]), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero(0, "mid_rst");
      go(3);
      exp_we               = 1'b1;
      exp_idx              = 3'd0;
      {exp_addr, exp_data} = E(0, 99);
      tick();
      exp_we = 1'b0;
      store(E(0, 1), 0);
      store(E(4, 2), 0);
      chk("rerun.busy", 32'(w_busy[0]), 1);
      store(E(8, 3), 0);
      @(negedge clk);
      chk("rerun.pass", 32'(w_pass[0]), 1);
      chk("rerun.match", 32'(w_mc[0]), 3);
      chk("rerun.mis", 32'(w_mis[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
